turn_resolver: RTL and testbench
================================

// Module: turn_resolver
// PURPOSE
//   Parametrised turn/move controller for the board game: selects a source piece, then a destination,
//   validates the move against a synchronous board RAM, scans scout paths, and resolves combat.
//   It then issues one move command to the board-update logic over a valid/ready handshake and passes the turn.
//   Sits between the mouse/cursor front end and the board store; replaces the fixed 8x8 two-step mover.
// PARAMETERS
//   COLS      8   board columns (2..2**XW)
//   ROWS      8   board rows (2..2**YW)
//   XW        3   x coordinate width
//   YW        3   y coordinate width
//   RANK_W    5   rank field width; cell = {team, rank}, CELL_W = RANK_W+1
//   TOP_RANK  7   rank code of the piece a spy may kill when attacking
//   SCOUT_EN  1   1: scout (rank 4) may move >1 cell in a straight, clear line
//   TURN_CYC  0   turn timeout in clk cycles (0 = disabled)
// PORTS
//   clk        in   1         clock
//   resetn     in   1         asynchronous active-low reset
//   go         in   1         1-cycle confirm pulse from the cursor front end
//   back       in   1         1-cycle cancel pulse (destination select only)
//   sel_x      in   XW        cursor column
//   sel_y      in   YW        cursor row
//   rd_x       out  XW        board read column (registered)
//   rd_y       out  YW        board read row (registered)
//   rd_cell    in   RANK_W+1  board data, valid the cycle after rd_x/rd_y change
//   cmd_valid  out  1         command offered
//   cmd_ready  in   1         board logic accepts command
//   cmd        out  2         00 MOVE/CAPTURE, 01 DIE, 10 TRADE, 11 WIN (flag taken)
//   src_x,src_y out XW,YW     command source; dst_x,dst_y out XW,YW destination
//   turn_player out 1         side to move
//   phase      out  4         current FSM state code (debug LEDs)
//   err        out  1         1-cycle pulse on any rejected selection or timeout
// BEHAVIOUR
//   Reset (async, resetn=0): phase=SRC, turn_player=0, cmd_valid=0, cmd=0, err=0, rd/src/dst=0, timer=0.
//   Cell codes: 0 blank; all-ones impassable; else {team,rank}. Ranks: 1 flag, 2 bomb, 3 spy, 4 scout, 5 miner.
//   States: SRC(0) SRC_RD(1) SRC_CHK(2) DST(3) PATH(4) DST_RD(5) DST_CHK(6) ISSUE(7) SWAP(8).
//   SRC: on go, latch sel into src and rd -> SRC_RD (1-cycle RAM wait) -> SRC_CHK.
//   SRC_CHK: pass if cell non-blank, not impassable, team==turn_player, rank not flag/bomb -> DST; else err, -> SRC.
//   DST: back -> SRC, no err. On go, latch dst. Reject (err, stay DST) if dst==src, or not same row/column.
//     Also reject if |dx|+|dy|>1 unless SCOUT_EN and src rank==4. Adjacent -> DST_RD.
//     A scout move >1 -> PATH.
//   PATH: read intermediate cells one per cycle (src+step .. dst-step), each compared the cycle after its address.
//     Any non-blank -> err, -> DST. All blank -> DST_RD.
//   DST_CHK: impassable or own team -> err, -> DST. Blank -> cmd=MOVE.
//     Enemy: resolve in priority order:
//     equal rank -> TRADE; flag -> WIN; bomb -> MOVE if attacker miner else DIE;
//     attacker spy & defender TOP_RANK -> MOVE; defender spy -> MOVE;
//     attacker rank > defender -> MOVE else DIE. Then -> ISSUE.
//   ISSUE: cmd_valid=1 with cmd/src/dst stable until cmd_ready sampled high (accept allowed on first cycle).
//     cmd_valid drops the next cycle -> SWAP. go/back ignored in ISSUE.
//   SWAP: toggle turn_player, clear timer -> SRC (exactly one cycle).
//   Timeout (TURN_CYC>0): timer counts in SRC..DST_CHK and PATH, clears in SWAP.
//     At TURN_CYC: err, toggle turn_player, -> SRC (no command issued).
//   go and back in the same cycle: back wins in DST; go wins in SRC. Cursor inputs outside COLS/ROWS are rejected (err).
//   Unsigned coordinate arithmetic at XW+1/YW+1 bits; no wrap-around allowed.
// TESTING
//   T1 reset mid-ISSUE (cmd_valid=1) -> next cycle cmd_valid=0, phase=0, turn_player=0.
//   T2 P0 rank 6 at (2,2) -> (2,3) blank; cmd_ready tied 1 -> cmd=00, src=(2,2), dst=(2,3), one valid pulse, turn_player=1.
//   T3 P0 rank 5 attacks P1 bomb -> cmd=00; P0 rank 6 attacks P1 bomb -> cmd=01; rank 6 vs rank 6 -> cmd=10.
//   T4 P0 spy attacks P1 rank 7 -> cmd=00; P1 rank 7 attacks P0 spy -> cmd=00; attack flag -> cmd=11.
//   T5 scout (0,0) -> (0,5) with (0,3) occupied -> err pulse, phase=3; clear (0,3), retry -> cmd=00 after 4 PATH reads.
//   T6 select own bomb -> err, phase=0. Select opponent piece -> err. Back in DST -> phase=0.
//     TURN_CYC=20, idle -> err at cycle 20, turn_player toggles.

Source files
------------

// File: rtl/turn_resolver.sv
// turn_resolver: turn/move controller for the board game. Picks a source piece
// and a destination, validates both against a synchronous board RAM, scans the
// straight path of long scout moves, resolves combat and hands a single move
// command to the board-update logic before passing the turn.
module turn_resolver #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int XW       = 3,
  parameter int YW       = 3,
  parameter int RANK_W   = 5,
  parameter int TOP_RANK = 7,
  parameter int SCOUT_EN = 1,
  parameter int TURN_CYC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              back,
  input  logic [XW-1:0]     sel_x,
  input  logic [YW-1:0]     sel_y,
  output logic [XW-1:0]     rd_x,
  output logic [YW-1:0]     rd_y,
  input  logic [RANK_W:0]   rd_cell,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd,
  output logic [XW-1:0]     src_x,
  output logic [YW-1:0]     src_y,
  output logic [XW-1:0]     dst_x,
  output logic [YW-1:0]     dst_y,
  output logic              turn_player,
  output logic [3:0]        phase,
  output logic              err
);

  localparam int CELL_W = RANK_W + 1;
  localparam int TW     = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  localparam logic [RANK_W-1:0] R_FLAG  = RANK_W'(1);
  localparam logic [RANK_W-1:0] R_BOMB  = RANK_W'(2);
  localparam logic [RANK_W-1:0] R_SPY   = RANK_W'(3);
  localparam logic [RANK_W-1:0] R_SCOUT = RANK_W'(4);
  localparam logic [RANK_W-1:0] R_MINER = RANK_W'(5);
  localparam logic [RANK_W-1:0] R_TOP   = RANK_W'(TOP_RANK);

  localparam logic [1:0] C_MOVE  = 2'b00;
  localparam logic [1:0] C_DIE   = 2'b01;
  localparam logic [1:0] C_TRADE = 2'b10;
  localparam logic [1:0] C_WIN   = 2'b11;

  typedef enum logic [3:0] {
    S_SRC     = 4'd0,
    S_SRC_RD  = 4'd1,
    S_SRC_CHK = 4'd2,
    S_DST     = 4'd3,
    S_PATH    = 4'd4,
    S_DST_RD  = 4'd5,
    S_DST_CHK = 4'd6,
    S_ISSUE   = 4'd7,
    S_SWAP    = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       rd_x_q, rd_x_d, src_x_q, src_x_d, dst_x_q, dst_x_d;
  logic [YW-1:0]       rd_y_q, rd_y_d, src_y_q, src_y_d, dst_y_q, dst_y_d;
  logic [RANK_W-1:0]   src_rank_q, src_rank_d;
  logic [1:0]          cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                turn_q, turn_d;
  logic                err_q, err_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                chk_vld_q, chk_vld_d;
  logic                chk_last_q, chk_last_d;

  // One step from cur toward the destination along the axis of the move.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] cur, input logic [XW-1:0] from,
                                           input logic [XW-1:0] to);
    if (to > from) return cur + XW'(1);
    else if (to < from) return cur - XW'(1);
    else return cur;
  endfunction

  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] cur, input logic [YW-1:0] from,
                                           input logic [YW-1:0] to);
    if (to > from) return cur + YW'(1);
    else if (to < from) return cur - YW'(1);
    else return cur;
  endfunction

  // Combat outcome for an attacker of rank att hitting a defender of rank def.
  function automatic logic [1:0] resolve(input logic [RANK_W-1:0] att, input logic [RANK_W-1:0] def);
    if (att == def) return C_TRADE;
    else if (def == R_FLAG) return C_WIN;
    else if (def == R_BOMB) return (att == R_MINER) ? C_MOVE : C_DIE;
    else if (att == R_SPY && def == R_TOP) return C_MOVE;
    else if (def == R_SPY) return C_MOVE;
    else if (att > def) return C_MOVE;
    else return C_DIE;
  endfunction

  logic [XW:0]       sel_xe, src_xe, dx_abs;
  logic [YW:0]       sel_ye, src_ye, dy_abs;
  logic              sel_in, line_ok, adjacent, scout_ok, rd_mid, counting, timeout;
  logic [XW-1:0]     path_nx;
  logic [YW-1:0]     path_ny;
  logic [RANK_W-1:0] cell_rank;
  logic              cell_team, cell_blank, cell_wall;

  // Decode the cursor, the requested displacement and the cell being read.
  always_comb begin
    sel_xe     = {1'b0, sel_x};
    sel_ye     = {1'b0, sel_y};
    src_xe     = {1'b0, src_x_q};
    src_ye     = {1'b0, src_y_q};
    sel_in     = (sel_xe < (XW+1)'(COLS)) && (sel_ye < (YW+1)'(ROWS));
    dx_abs     = (sel_xe >= src_xe) ? sel_xe - src_xe : src_xe - sel_xe;
    dy_abs     = (sel_ye >= src_ye) ? sel_ye - src_ye : src_ye - sel_ye;
    // Exactly one axis unchanged: same row or column, and not the source itself.
    line_ok    = (dx_abs == '0) != (dy_abs == '0);
    adjacent   = line_ok && ((dx_abs == (XW+1)'(1)) || (dy_abs == (YW+1)'(1)));
    scout_ok   = (SCOUT_EN != 0) && (src_rank_q == R_SCOUT);
    rd_mid     = (rd_x_q != dst_x_q) || (rd_y_q != dst_y_q);
    path_nx    = step_x(rd_x_q, src_x_q, dst_x_q);
    path_ny    = step_y(rd_y_q, src_y_q, dst_y_q);
    cell_rank  = rd_cell[RANK_W-1:0];
    cell_team  = rd_cell[RANK_W];
    cell_blank = (rd_cell == '0);
    cell_wall  = (rd_cell == {CELL_W{1'b1}});
    counting   = (state_q != S_ISSUE) && (state_q != S_SWAP);
    timeout    = (TURN_CYC > 0) && counting && (timer_q == TMAX);
  end

  // Next-state and datapath updates for the turn sequence.
  always_comb begin
    state_d     = state_q;
    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    src_rank_d  = src_rank_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    turn_d      = turn_q;
    err_d       = 1'b0;
    timer_d     = timer_q;
    chk_vld_d   = 1'b0;
    chk_last_d  = 1'b0;
    if (TURN_CYC > 0 && counting) timer_d = timer_q + TW'(1);

    case (state_q)
      S_SRC: begin
        if (go) begin
          if (sel_in) begin
            src_x_d = sel_x;
            src_y_d = sel_y;
            rd_x_d  = sel_x;
            rd_y_d  = sel_y;
            state_d = S_SRC_RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SRC_RD: state_d = S_SRC_CHK;
      S_SRC_CHK: begin
        if (!cell_blank && !cell_wall && cell_team == turn_q &&
            cell_rank != R_FLAG && cell_rank != R_BOMB) begin
          src_rank_d = cell_rank;
          state_d    = S_DST;
        end else begin
          err_d   = 1'b1;
          state_d = S_SRC;
        end
      end
      S_DST: begin
        if (back) begin
          state_d = S_SRC;
        end else if (go) begin
          dst_x_d = sel_x;
          dst_y_d = sel_y;
          if (!sel_in || !line_ok) begin
            err_d = 1'b1;
          end else if (adjacent) begin
            rd_x_d  = sel_x;
            rd_y_d  = sel_y;
            state_d = S_DST_RD;
          end else if (scout_ok) begin
            rd_x_d  = step_x(src_x_q, src_x_q, sel_x);
            rd_y_d  = step_y(src_y_q, src_y_q, sel_y);
            state_d = S_PATH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PATH: begin
        // rd_cell lags the address by a cycle, so chk_vld/chk_last describe
        // the intermediate cell addressed in the previous cycle.
        if (rd_mid) begin
          rd_x_d     = path_nx;
          rd_y_d     = path_ny;
          chk_vld_d  = 1'b1;
          chk_last_d = (path_nx == dst_x_q) && (path_ny == dst_y_q);
        end
        if (chk_vld_q && !cell_blank) begin
          err_d   = 1'b1;
          state_d = S_DST;
        end else if (chk_vld_q && chk_last_q) begin
          state_d = S_DST_RD;
        end
      end
      S_DST_RD: state_d = S_DST_CHK;
      S_DST_CHK: begin
        if (cell_wall || (!cell_blank && cell_team == turn_q)) begin
          err_d   = 1'b1;
          state_d = S_DST;
        end else begin
          cmd_d       = cell_blank ? C_MOVE : resolve(src_rank_q, cell_rank);
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_SWAP;
        end
      end
      S_SWAP: begin
        turn_d  = ~turn_q;
        timer_d = '0;
        state_d = S_SRC;
      end
      default: state_d = S_SRC;
    endcase

    if (timeout) begin
      state_d     = S_SRC;
      err_d       = 1'b1;
      turn_d      = ~turn_q;
      timer_d     = '0;
      cmd_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_SRC;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      src_rank_q  <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      turn_q      <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      chk_vld_q   <= 1'b0;
      chk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      src_rank_q  <= src_rank_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      turn_q      <= turn_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      chk_vld_q   <= chk_vld_d;
      chk_last_q  <= chk_last_d;
    end
  end

  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign src_x       = src_x_q;
  assign src_y       = src_y_q;
  assign dst_x       = dst_x_q;
  assign dst_y       = dst_y_q;
  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign turn_player = turn_q;
  assign phase       = state_q;
  assign err         = err_q;

endmodule

// File: tb/tb_turn_resolver.sv
// Directed bench for turn_resolver: a behavioural board RAM feeds the main
// instance; a second instance with a 20-cycle turn timeout is left idle.
module tb_turn_resolver;
  logic       clk = 1'b0;
  logic       resetn, go, back, cmd_ready;
  logic [2:0] sel_x, sel_y, rd_x, rd_y, src_x, src_y, dst_x, dst_y;
  logic [5:0] rd_cell;
  logic       cmd_valid, turn_player, err;
  logic [1:0] cmd;
  logic [3:0] phase;

  logic [2:0] rd_x2, rd_y2, src_x2, src_y2, dst_x2, dst_y2;
  logic       cmd_valid2, turn2, err2;
  logic [1:0] cmd2;
  logic [3:0] phase2;

  logic [5:0] board [0:7][0:7];
  int n_cmp = 0, n_bad = 0, err_seen = 0, exp_turn = 0;

  turn_resolver dut (
    .clk(clk), .resetn(resetn), .go(go), .back(back), .sel_x(sel_x), .sel_y(sel_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .turn_player(turn_player), .phase(phase), .err(err)
  );

  turn_resolver #(.TURN_CYC(20)) dut_to (
    .clk(clk), .resetn(resetn), .go(1'b0), .back(1'b0), .sel_x(3'd0), .sel_y(3'd0),
    .rd_x(rd_x2), .rd_y(rd_y2), .rd_cell(6'd0), .cmd_valid(cmd_valid2), .cmd_ready(1'b1),
    .cmd(cmd2), .src_x(src_x2), .src_y(src_y2), .dst_x(dst_x2), .dst_y(dst_y2),
    .turn_player(turn2), .phase(phase2), .err(err2)
  );

  always #5 clk = ~clk;

  // Synchronous board RAM: data appears the cycle after the address.
  always @(posedge clk) rd_cell <= board[rd_y][rd_x];

  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) board[y][x] = 6'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; go = 1'b0; back = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_turn = 0;
  endtask

  task automatic press(input int x, input int y);
    @(negedge clk);
    sel_x = 3'(x); sel_y = 3'(y); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic press_back();
    @(negedge clk);
    back = 1'b1;
    @(negedge clk);
    back = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 32'(cmd_valid), 1);
  endtask

  task automatic finish_move(input string tag, input int sx, input int sy, input int dx, input int dy,
                             input int exp_cmd);
    check({tag, ".cmd"}, 32'(cmd), exp_cmd);
    check({tag, ".src"}, 32'({src_x, src_y}), sx * 8 + sy);
    check({tag, ".dst"}, 32'({dst_x, dst_y}), dx * 8 + dy);
    @(negedge clk);
    check({tag, ".valid_drop"}, 32'(cmd_valid), 0);
    check({tag, ".swap"}, 32'(phase), 8);
    @(negedge clk);
    exp_turn ^= 1;
    check({tag, ".turn"}, 32'(turn_player), exp_turn);
    check({tag, ".back_src"}, 32'(phase), 0);
  endtask

  task automatic run_move(input string tag, input int sx, input int sy, input int dx, input int dy,
                          input int exp_cmd);
    press(sx, sy);
    repeat (2) @(negedge clk);
    check({tag, ".in_dst"}, 32'(phase), 3);
    press(dx, dy);
    wait_valid(tag);
    finish_move(tag, sx, sy, dx, dy, exp_cmd);
  endtask

  initial begin
    int e0, cnt, n, e2;
    resetn = 1'b0; go = 1'b0; back = 1'b0; cmd_ready = 1'b1;
    sel_x = 3'd0; sel_y = 3'd0;
    clear_board();
    repeat (3) @(negedge clk);
    check("rst.phase", 32'(phase), 0);
    check("rst.turn", 32'(turn_player), 0);
    check("rst.valid", 32'(cmd_valid), 0);
    check("rst.cmd", 32'(cmd), 0);
    check("rst.err", 32'(err), 0);
    check("rst.rd", 32'({rd_x, rd_y}), 0);
    check("rst.src_dst", 32'({src_x, src_y, dst_x, dst_y}), 0);
    @(negedge clk);
    resetn = 1'b1;

    // T2: plain move onto a blank cell
    board[2][2] = 6'h06;
    run_move("t2", 2, 2, 2, 3, 0);

    // T1: P1 move stalled in ISSUE, then reset
    board[5][5] = 6'h26;
    cmd_ready = 1'b0;
    press(5, 5);
    repeat (2) @(negedge clk);
    check("t1.in_dst", 32'(phase), 3);
    press(5, 4);
    wait_valid("t1");
    repeat (3) @(negedge clk);
    check("t1.hold_valid", 32'(cmd_valid), 1);
    check("t1.hold_phase", 32'(phase), 7);
    resetn = 1'b0;
    #1;
    check("t1.rst_valid", 32'(cmd_valid), 0);
    check("t1.rst_phase", 32'(phase), 0);
    check("t1.rst_turn", 32'(turn_player), 0);
    @(negedge clk);
    resetn = 1'b1; cmd_ready = 1'b1; exp_turn = 0;

    // T3: bombs and trades
    clear_board(); board[1][1] = 6'h05; board[2][1] = 6'h22;
    run_move("t3.miner_bomb", 1, 1, 1, 2, 0);
    apply_reset(); board[1][1] = 6'h06;
    run_move("t3.r6_bomb", 1, 1, 1, 2, 1);
    apply_reset(); board[2][1] = 6'h26;
    run_move("t3.trade", 1, 1, 1, 2, 2);

    // T4: spy rules, flag capture, weaker attacker
    apply_reset(); clear_board();
    board[3][3] = 6'h03; board[3][4] = 6'h27;
    run_move("t4.spy_att", 3, 3, 4, 3, 0);
    board[6][6] = 6'h27; board[7][6] = 6'h03;
    run_move("t4.spy_def", 6, 6, 6, 7, 0);
    board[7][0] = 6'h06; board[7][1] = 6'h21;
    run_move("t4.flag", 0, 7, 1, 7, 3);
    board[0][2] = 6'h25; board[0][3] = 6'h07;
    run_move("t4.weak", 2, 0, 3, 0, 1);

    // T5: scout path blocked, then cleared
    apply_reset(); clear_board();
    board[0][0] = 6'h04; board[3][0] = 6'h25;
    press(0, 0);
    settle(2);
    check("t5.in_dst", 32'(phase), 3);
    e0 = err_seen;
    press(0, 5);
    settle(8);
    check("t5.block_err", 32'(err_seen - e0), 1);
    check("t5.block_phase", 32'(phase), 3);
    board[3][0] = 6'h00;
    press(0, 5);
    cnt = 0; n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      if (phase == 4'd4 && {rd_x, rd_y} != {3'd0, 3'd5}) cnt++;
      @(negedge clk);
      n++;
    end
    check("t5.valid", 32'(cmd_valid), 1);
    check("t5.path_reads", 32'(cnt), 4);
    finish_move("t5", 0, 0, 0, 5, 0);

    // T6: rejected selections, back, timeout
    apply_reset(); clear_board();
    board[4][4] = 6'h02; board[5][4] = 6'h26; board[6][4] = 6'h06;
    #1 e0 = err_seen;
    press(4, 4);
    settle(3);
    check("t6.bomb_err", 32'(err_seen - e0), 1);
    check("t6.bomb_phase", 32'(phase), 0);
    e0 = err_seen;
    press(4, 5);
    settle(3);
    check("t6.opp_err", 32'(err_seen - e0), 1);
    check("t6.opp_phase", 32'(phase), 0);
    press(4, 6);
    settle(2);
    check("t6.in_dst", 32'(phase), 3);
    e0 = err_seen;
    press(5, 7);
    settle(2);
    check("t6.diag_err", 32'(err_seen - e0), 1);
    check("t6.diag_phase", 32'(phase), 3);
    e0 = err_seen;
    press(4, 4);
    settle(2);
    check("t6.far_err", 32'(err_seen - e0), 1);
    e0 = err_seen;
    press(4, 6);
    settle(2);
    check("t6.same_err", 32'(err_seen - e0), 1);
    check("t6.same_phase", 32'(phase), 3);
    e0 = err_seen;
    press_back();
    settle(2);
    check("t6.back_phase", 32'(phase), 0);
    check("t6.back_noerr", 32'(err_seen - e0), 0);

    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    e2 = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (err2 === 1'b1) e2++;
    end
    check("t6.to_quiet", 32'(e2), 0);
    check("t6.to_turn0", 32'(turn2), 0);
    @(negedge clk);
    check("t6.to_err", 32'(err2), 1);
    check("t6.to_turn1", 32'(turn2), 1);
    check("t6.to_phase", 32'(phase2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
